dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Owns the single data-memory port and shares it between the MEM stage and the Debug Unit.
//  While the CPU runs, MEM-stage read/write strobes pass through untouched.
//  After a halt, a Debug Unit dump request walks every memory word and streams it out
//  over a valid/ready handshake (one word per handshake).
//  Sits between the MEM/WB latch logic and DATA_MEM; the Debug Unit is the second requester.
// PARAMETERS
//  len_data   32  memory word width
//  len_addr   6   word-address width
//  num_words  64  words dumped per request (<= 2**len_addr)
// PORTS
//  clk         in   1         system clock, all state on posedge
//  reset       in   1         asynchronous, active-low reset (0 = reset)
//  pipe_rd     in   1         MEM-stage MemRead
//  pipe_wr     in   1         MEM-stage MemWrite
//  pipe_addr   in   len_addr  MEM-stage word address
//  pipe_wdata  in   len_data  MEM-stage store data (already SB/SH-formatted)
//  pipe_halted in   1         halt flag registered at MEM/WB (CPU frozen)
//  dump_req    in   1         Debug Unit dump request (level, sampled)
//  dbg_ready   in   1         Debug Unit can accept a word
//  mem_rdata   in   len_data  DATA_MEM read data, valid 1 cycle after mem_rd
//  mem_rd      out  1         DATA_MEM read strobe
//  mem_wr      out  1         DATA_MEM write strobe
//  mem_addr    out  len_addr  DATA_MEM address
//  mem_wdata   out  len_data  DATA_MEM write data
//  dbg_valid   out  1         dbg_data/dbg_addr hold a valid word
//  dbg_data    out  len_data  dumped word
//  dbg_addr    out  len_addr  address of dumped word
//  dump_busy   out  1         dump in progress (memory owned by debug)
//  dump_done   out  1         one-cycle pulse after last word is accepted
//  collide_err out  1         sticky: pipe_rd/pipe_wr seen while dump_busy
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, counter=0, every output 0; collide_err cleared.
//  FSM IDLE: mem_* = pipe_* combinationally (zero added latency); dbg_valid=0.
//   dump_req=1 & pipe_halted=1 -> RD, counter=0. dump_req=1 & pipe_halted=0 -> stay in IDLE
//   (request pends until halt; nothing is lost).
//  RD: mem_rd=1, mem_wr=0, mem_addr=counter; next -> CAP. dump_busy=1 in RD, CAP and SEND.
//  CAP: register mem_rdata->dbg_data and counter->dbg_addr; next -> SEND.
//  SEND: dbg_valid=1; dbg_data/dbg_addr held stable until dbg_ready=1.
//   ready & counter==num_words-1 -> IDLE, dump_done=1 for one cycle, counter=0.
//   ready otherwise -> counter+1, RD.
//  Throughput: 3 cycles per word when dbg_ready is tied high; a dump of 64 words takes 192 cycles.
//  Counter is len_addr bits; it never wraps past num_words-1.
//  In RD/CAP/SEND: mem_wr is forced 0 and pipe_* is ignored. pipe_rd|pipe_wr=1 sets collide_err.
//  collide_err clears only on reset.
//  pipe_halted dropping mid-dump: the dump still completes; the pipeline must stay stalled
//  (collide_err flags any violation).
//  dump_req held high after dump_done: no new dump starts until dump_req is seen low for >=1 cycle
//  (edge-armed flag).
//  Reset mid-dump: FSM aborts immediately to IDLE with no dump_done pulse.
// STRUCTURE
//  localparams for the state encoding (IDLE/RD/CAP/SEND, 2 bits) go in the shared
//  mips_defs include, next to the memory_bus bit indices.
//  No sub-module: the FSM, counter and output mux are all in this file.
// TESTING
//  1 Pass-through: state IDLE, pipe_wr=1, addr=5, wdata=0xDEADBEEF -> same cycle mem_wr=1,
//    mem_addr=5, mem_wdata=0xDEADBEEF.
//  2 Full dump: preload mem[i]=i*4, pipe_halted=1, dump_req pulse, dbg_ready=1 -> 64 words
//    in address order, dbg_data=i*4; dump_done pulses once, at cycle 192.
//  3 Backpressure: dbg_ready=0 for 10 cycles on word 7 -> dbg_valid stays 1 and
//    dbg_addr=7/data stable; word 8 follows only after ready.
//  4 Pending request: dump_req=1 while pipe_halted=0 -> no mem_rd; set pipe_halted=1 ->
//    RD starts next cycle at addr 0.
//  5 Collision: pipe_wr=1 during SEND -> mem_wr stays 0, collide_err=1 and stays 1 after dump_done.
//  6 Reset at word 20 -> all outputs 0 in the same cycle; no dump_done; a new dump_req
//    restarts at addr 0.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared definitions for the data-memory port arbiter: FSM state encoding,
//   default geometry of the data memory and small decode helpers.
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

    // Arbiter FSM state encoding (2 bits, kept as plain constants so the
    // encoding stays stable for legacy tooling that probes the state register).
    localparam logic [1:0] ST_IDLE = 2'd0;  // pipeline owns the port
    localparam logic [1:0] ST_RD   = 2'd1;  // issue read for current dump word
    localparam logic [1:0] ST_CAP  = 2'd2;  // capture read data into dbg regs
    localparam logic [1:0] ST_SEND = 2'd3;  // present word, wait for dbg_ready

    // Default data-memory geometry.
    localparam int DEF_LEN_DATA  = 32;
    localparam int DEF_LEN_ADDR  = 6;
    localparam int DEF_NUM_WORDS = 64;

    // True in every state where the debug side owns the memory port.
    function automatic logic is_dump_state(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

    // True in the single state that issues the dump read strobe.
    function automatic logic is_read_state(input logic [1:0] st);
        return st == ST_RD;
    endfunction

endpackage : dmem_port_arbiter_pkg

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Owns the single data-memory port. While the CPU runs, MEM-stage strobes
//   pass straight through. Once the CPU is halted, a Debug Unit dump request
//   walks every memory word (RD -> CAP -> SEND per word) and streams it out
//   over a valid/ready handshake.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   pipe_rd/wr/addr/wdata      MEM-stage request
//   pipe_halted                CPU frozen (halt registered at MEM/WB)
//   dump_req                   Debug Unit dump request (level)
//   dbg_ready                  Debug Unit accepts the presented word
//   mem_rdata                  DATA_MEM read data, one cycle after mem_rd
//   mem_rd/wr/addr/wdata       DATA_MEM port
//   dbg_valid/data/addr        dumped word stream
//   dump_busy                  debug owns memory (RD/CAP/SEND)
//   dump_done                  one-cycle pulse after the last word is taken
//   collide_err                sticky: pipeline access seen during a dump
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int len_data  = DEF_LEN_DATA,
    parameter int len_addr  = DEF_LEN_ADDR,
    parameter int num_words = DEF_NUM_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pipe_rd,
    input  logic                pipe_wr,
    input  logic [len_addr-1:0] pipe_addr,
    input  logic [len_data-1:0] pipe_wdata,
    input  logic                pipe_halted,
    input  logic                dump_req,
    input  logic                dbg_ready,
    input  logic [len_data-1:0] mem_rdata,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [len_addr-1:0] mem_addr,
    output logic [len_data-1:0] mem_wdata,
    output logic                dbg_valid,
    output logic [len_data-1:0] dbg_data,
    output logic [len_addr-1:0] dbg_addr,
    output logic                dump_busy,
    output logic                dump_done,
    output logic                collide_err
);

    localparam logic [len_addr-1:0] LAST_WORD = len_addr'(num_words - 1);

    logic [1:0]          state;
    logic [len_addr-1:0] counter;
    logic                armed;     // dump_req has been low since the last dump started
    logic                busy;
    logic                start;
    logic                last;

    assign busy  = is_dump_state(state);
    assign last  = (counter == LAST_WORD);
    // A request pends in IDLE until the CPU is halted; the armed flag stops a
    // request held high across dump_done from retriggering.
    assign start = (state == ST_IDLE) && dump_req && pipe_halted && armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            counter     <= '0;
            armed       <= 1'b1;
            dbg_data    <= '0;
            dbg_addr    <= '0;
            dump_done   <= 1'b0;
            collide_err <= 1'b0;
        end else begin
            dump_done <= 1'b0;

            if (!dump_req)
                armed <= 1'b1;
            else if (start)
                armed <= 1'b0;

            if (busy && (pipe_rd || pipe_wr))
                collide_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RD;
                        counter <= '0;
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    dbg_data <= mem_rdata;
                    dbg_addr <= counter;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (dbg_ready) begin
                        if (last) begin
                            state     <= ST_IDLE;
                            counter   <= '0;
                            dump_done <= 1'b1;
                        end else begin
                            counter <= counter + len_addr'(1);
                            state   <= ST_RD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output mux. Everything is gated by reset so the combinational
    // pass-through also reads 0 while reset is asserted.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (!busy) begin
                mem_rd    = pipe_rd;
                mem_wr    = pipe_wr;
                mem_addr  = pipe_addr;
                mem_wdata = pipe_wdata;
            end else begin
                // Pipeline request ignored; writes can never reach memory.
                mem_rd   = is_read_state(state);
                mem_addr = counter;
            end
        end
    end

    assign dbg_valid = reset && (state == ST_SEND);
    assign dump_busy = reset && busy;

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    localparam int LD = 32;
    localparam int LA = 6;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pipe_rd = 1'b0, pipe_wr = 1'b0, pipe_halted = 1'b0;
    logic [LA-1:0] pipe_addr = '0;
    logic [LD-1:0] pipe_wdata = '0;
    logic          dump_req = 1'b0, dbg_ready = 1'b0;
    logic [LD-1:0] mem_rdata = '0;
    logic          mem_rd, mem_wr, dbg_valid, dump_busy, dump_done, collide_err;
    logic [LA-1:0] mem_addr, dbg_addr;
    logic [LD-1:0] mem_wdata, dbg_data;

    dmem_port_arbiter #(.len_data(LD), .len_addr(LA), .num_words(NW)) dut (
        .clk(clk), .reset(reset),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_halted(pipe_halted), .dump_req(dump_req), .dbg_ready(dbg_ready),
        .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_addr(dbg_addr),
        .dump_busy(dump_busy), .dump_done(dump_done), .collide_err(collide_err)
    );

    always #5 clk = ~clk;

    // DATA_MEM model: synchronous write, one-cycle read latency.
    logic [LD-1:0] mem [NW];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // Reference contents: what the bench itself has written through the port.
    logic [LD-1:0] mem_ref [NW];
    bit collide_exp = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [LA-1:0] a, input logic [LD-1:0] d);
        pipe_wr = 1'b1; pipe_addr = a; pipe_wdata = d;
        #1;
        chk("pt_mem_wr", 64'(mem_wr), 64'd1);
        chk("pt_mem_addr", 64'(mem_addr), 64'(a));
        chk("pt_mem_wdata", 64'(mem_wdata), 64'(d));
        tick();
        mem_ref[a] = d;
        pipe_wr = 1'b0;
    endtask

    task automatic random_writes(input int n);
        for (int k = 0; k < n; k++)
            pipe_write(LA'($urandom_range(0, NW - 1)), $urandom);
    endtask

    // mode 0: ready always; 1: ready low 10 cycles on word 7; 2: random ready.
    task automatic run_dump(input int mode, input int collide_word, input int abort_word,
                            input int halt_drop_word);
        int  idx = 0, start = -1, stalls = 0, stall_cnt = 0, cyc = 0;
        bit  fin = 0, aborted = 0, prev_stall = 0, collided = 0, r;
        while (!fin && cyc < 3000) begin
            if (dump_busy && start < 0) begin
                start = cyc;
                chk("first_mem_rd", 64'(mem_rd), 64'd1);
                chk("first_mem_addr", 64'(mem_addr), 64'd0);
            end
            if (dump_done) begin
                chk("done_cycle", 64'(cyc - start), 64'(192 + stalls));
                chk("done_words", 64'(idx), 64'(NW));
                fin = 1;
            end else begin
                if (prev_stall) chk("valid_held", 64'(dbg_valid), 64'd1);
                prev_stall = 0;
                if (dump_busy) chk("dump_mem_wr", 64'(mem_wr), 64'd0);
                if (dbg_valid) begin
                    chk("dbg_addr", 64'(dbg_addr), 64'(idx));
                    chk("dbg_data", 64'(dbg_data), 64'(mem_ref[idx]));
                    if (idx == abort_word) begin
                        dump_req = 1'b0;
                        reset = 1'b0;
                        #1;
                        chk("rst_mem_rd", 64'(mem_rd), 0);
                        chk("rst_mem_wr", 64'(mem_wr), 0);
                        chk("rst_mem_addr", 64'(mem_addr), 0);
                        chk("rst_mem_wdata", 64'(mem_wdata), 0);
                        chk("rst_dbg_valid", 64'(dbg_valid), 0);
                        chk("rst_dbg_data", 64'(dbg_data), 0);
                        chk("rst_dbg_addr", 64'(dbg_addr), 0);
                        chk("rst_dump_busy", 64'(dump_busy), 0);
                        chk("rst_dump_done", 64'(dump_done), 0);
                        chk("rst_collide_err", 64'(collide_err), 0);
                        collide_exp = 1'b0;
                        tick();
                        reset = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            tick();
                            chk("abort_no_done", 64'(dump_done), 0);
                            chk("abort_idle", 64'(dump_busy), 0);
                        end
                        aborted = 1;
                        fin = 1;
                    end
                    if (!aborted) begin
                        if (idx == collide_word && !collided) begin
                            pipe_wr = 1'b1; pipe_addr = LA'(idx); pipe_wdata = 32'hBAD0BAD0;
                            #1;
                            chk("collide_mem_wr", 64'(mem_wr), 0);
                            collided = 1; collide_exp = 1'b1;
                        end else begin
                            pipe_wr = 1'b0;
                        end
                        case (mode)
                            0: r = 1;
                            1: begin
                                r = !(idx == 7 && stall_cnt < 10);
                                if (!r) stall_cnt++;
                            end
                            default: r = ($urandom_range(0, 3) != 0);
                        endcase
                        dbg_ready = r;
                        if (!r) begin stalls++; prev_stall = 1; end
                        else idx++;
                    end
                end else begin
                    pipe_wr = 1'b0;
                    dbg_ready = 1'($urandom_range(0, 1));
                end
                if (idx == halt_drop_word) pipe_halted = 1'b0;
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        pipe_wr = 1'b0;
        if (!fin) chk("dump_timeout", 0, 1);
        if (!aborted) begin
            if (mode == 1) chk("stall_cycles", 64'(stalls), 64'd10);
            // dump_req still high: the dump must not restart.
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("no_restart_busy", 64'(dump_busy), 0);
                chk("done_single", 64'(dump_done), 0);
            end
            chk("collide_err", 64'(collide_err), 64'(collide_exp));
        end
    endtask

    initial begin
        // Reset with active pipeline inputs: everything must read 0.
        pipe_rd = 1'b1; pipe_wr = 1'b1; pipe_addr = 6'd9; pipe_wdata = 32'h12345678;
        #2;
        chk("reset_mem_rd", 64'(mem_rd), 0);
        chk("reset_mem_wr", 64'(mem_wr), 0);
        chk("reset_mem_addr", 64'(mem_addr), 0);
        chk("reset_dbg_valid", 64'(dbg_valid), 0);
        chk("reset_busy", 64'(dump_busy), 0);
        chk("reset_done", 64'(dump_done), 0);
        chk("reset_collide", 64'(collide_err), 0);
        pipe_rd = 1'b0; pipe_wr = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        pipe_write(6'd5, 32'hDEADBEEF);

        // Random pass-through traffic while idle.
        for (int k = 0; k < 20; k++) begin
            pipe_rd = 1'($urandom_range(0, 1));
            pipe_wr = 1'($urandom_range(0, 1));
            pipe_addr = LA'($urandom_range(0, NW - 1));
            pipe_wdata = $urandom;
            #1;
            chk("rnd_mem_rd", 64'(mem_rd), 64'(pipe_rd));
            chk("rnd_mem_wr", 64'(mem_wr), 64'(pipe_wr));
            chk("rnd_mem_addr", 64'(mem_addr), 64'(pipe_addr));
            chk("rnd_mem_wdata", 64'(mem_wdata), 64'(pipe_wdata));
            tick();
            if (pipe_wr) mem_ref[pipe_addr] = pipe_wdata;
        end
        pipe_rd = 1'b0; pipe_wr = 1'b0;

        for (int i = 0; i < NW; i++) pipe_write(LA'(i), LD'(i * 4));

        // Pending request: nothing happens until the CPU halts.
        dump_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pend_mem_rd", 64'(mem_rd), 0);
            chk("pend_busy", 64'(dump_busy), 0);
        end
        pipe_halted = 1'b1;
        tick();
        run_dump(0, -1, -1, -1);
        dump_req = 1'b0;
        tick();

        // Backpressure on word 7 plus a pipeline write colliding with SEND.
        random_writes(16);
        dump_req = 1'b1;
        run_dump(1, 12, -1, -1);
        dump_req = 1'b0;
        tick();

        // Random ready; halt drops mid-dump but the dump still completes.
        random_writes(16);
        dump_req = 1'b1;
        run_dump(2, -1, -1, 30);
        pipe_halted = 1'b1;
        dump_req = 1'b0;
        tick();

        // Reset at word 20, then a fresh dump restarts from address 0.
        dump_req = 1'b1;
        run_dump(0, -1, 20, -1);
        random_writes(8);
        dump_req = 1'b1;
        run_dump(0, -1, -1, -1);
        dump_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
